fifo_uart_tx_bridge: RTL and testbench
======================================

// Module: fifo_uart_tx_bridge
// PURPOSE
//   Downstream consumer of the 32-bit command FIFO.
//   Pops one word whenever the FIFO is non-empty and the link is idle.
//   Serialises each word as 4 UART frames (8N1) towards the robot radio link.
//   Runs in the FIFO read-clock domain; FIFO is normal (non-show-ahead) mode,
//   so q is valid one cycle after rdreq.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200 baud); legal >= 2
//   MSB_FIRST     1    1: byte [31:24] sent first; 0: byte [7:0] sent first
// PORTS
//   clk        in   1   single clock (same as FIFO rdclk)
//   reset      in   1   synchronous, active-high
//   rdempty    in   1   FIFO empty flag
//   q          in   32  FIFO read data, valid the cycle after rdreq
//   rdreq      out  1   FIFO read request, registered, one-cycle pulse per word
//   tx         out  1   UART serial output, idle high
//   busy       out  1   high from rdreq cycle until end of last stop bit
//   word_done  out  1   one-cycle pulse in the cycle after the 4th stop bit ends
// BEHAVIOUR
//   Reset values: rdreq=0, tx=1, busy=0, word_done=0, state=IDLE; all counters 0.
//   States: IDLE -> READ -> LATCH -> START -> DATA -> STOP -> (START | DONE) -> IDLE.
//   IDLE : tx=1. If rdempty=0 sampled at edge k, go READ; rdreq=1 in cycle k+1.
//   READ : rdreq high exactly one cycle; go LATCH. busy=1 from here.
//   LATCH: q captured into 32-bit word register at edge k+2; byte_idx=0; go START.
//   START: tx=0 for CLKS_PER_BIT cycles (first start bit begins cycle k+3).
//   DATA : 8 bits, LSB of current byte first, each CLKS_PER_BIT cycles.
//   STOP : tx=1 for CLKS_PER_BIT cycles; if byte_idx<3 then byte_idx++ and go START
//          with no idle gap, else go DONE.
//   DONE : word_done=1, busy=0, tx=1 for one cycle; go IDLE.
//   Byte order: MSB_FIRST=1 -> [31:24],[23:16],[15:8],[7:0]; else reverse.
//   Baud counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit counter 0..7.
//   Word frame length: 4*10*CLKS_PER_BIT cycles from first start bit to DONE.
//   Back-to-back: if rdempty=0 during DONE, IDLE issues next rdreq one cycle later
//     (minimum 2 idle-high cycles between words).
//   rdempty and q are ignored outside IDLE and LATCH respectively.
//   rdreq never asserted while rdempty=1 sampled in the same decision cycle;
//     never more than one rdreq per word.
//   Reset mid-operation: next cycle tx=1, busy=0, rdreq=0; word in flight discarded,
//     no partial word_done.
//   tx is a registered output (no glitches).
// TESTING (bench uses CLKS_PER_BIT=4 and a behavioural FIFO model)
//   Empty FIFO for 200 cycles -> rdreq never high, tx=1, busy=0.
//   One word 0xA1B2C3D4, MSB_FIRST=1 -> exactly one rdreq pulse; tx decodes
//     A1,B2,C3,D4; start bit 2 cycles after rdreq; word_done 160 cycles after
//     first start bit.
//   Same word, MSB_FIRST=0 -> tx decodes D4,C3,B2,A1.
//   Two queued words 0x00000001, 0xFFFFFFFF -> two rdreq pulses; second rdreq
//     exactly 1 cycle after word_done; decoded bytes 00,00,00,01,FF,FF,FF,FF.
//   Reset asserted during 2nd data bit of byte 1 -> tx=1 and busy=0 next cycle;
//     after release with empty FIFO, no further rdreq or tx activity.
//   rdempty toggled randomly during a word -> no extra rdreq; frame timing unchanged.

Source files
------------

// File: rtl/fifo_uart_tx_bridge.sv
// fifo_uart_tx_bridge
//   Drains 32-bit command words from a normal-mode (non-show-ahead) FIFO and
//   sends each word as four 8N1 UART frames towards the robot radio link.
//   The whole block lives in the FIFO read-clock domain.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit, must be >= 2
//   MSB_FIRST     1: byte [31:24] goes out first, 0: byte [7:0] goes out first
//
// Ports
//   clk        in   1   FIFO read clock
//   reset      in   1   synchronous, active-high
//   rdempty    in   1   FIFO empty flag, only looked at when a new word may start
//   q          in   32  FIFO read data, valid the cycle after rdreq
//   rdreq      out  1   registered one-cycle read request, one per word
//   tx         out  1   registered UART serial output, idle high
//   busy       out  1   high from the rdreq cycle until the last stop bit ends
//   word_done  out  1   one-cycle pulse right after the fourth stop bit

module fifo_uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdempty,
  input  logic [31:0] q,
  output logic        rdreq,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
    STOP,
    DONE
  } stateT;

  stateT             state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0]        bitCnt, bitNext;
  logic [1:0]        byteIdx, byteNext;
  logic [31:0]       wordReg, wordNext;
  logic              rdreqNext, txNext, busyNext, wordDoneNext;
  logic              lastBaud;
  logic [7:0]        curByte;

  // Maps the transmit slot (0 = first byte on the wire) onto a byte lane of
  // the latched word, honouring the configured byte order.
  function automatic logic [7:0] pickByte(input logic [31:0] w, input logic [1:0] slot);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - slot) : slot;
    case (lane)
      2'd0:    pickByte = w[7:0];
      2'd1:    pickByte = w[15:8];
      2'd2:    pickByte = w[23:16];
      default: pickByte = w[31:24];
    endcase
  endfunction

  assign lastBaud = (baudCnt == BAUD_LAST);

  // Next-state logic for the sequencer and its counters. The outputs are
  // decoded from the *next* state so they can be registered alongside the
  // state itself, which keeps tx glitch-free and lines rdreq up with READ.
  // DONE makes the same fetch decision IDLE would, so a waiting word gets its
  // rdreq in the cycle straight after word_done.
  always_comb begin
    stateNext    = state;
    baudNext     = baudCnt;
    bitNext      = bitCnt;
    byteNext     = byteIdx;
    wordNext     = wordReg;
    rdreqNext    = 1'b0;
    txNext       = 1'b1;
    busyNext     = 1'b0;
    wordDoneNext = 1'b0;
    curByte      = 8'h00;

    case (state)
      IDLE: begin
        if (!rdempty) stateNext = READ;
      end
      READ: begin
        stateNext = LATCH;
      end
      LATCH: begin
        wordNext  = q;
        byteNext  = 2'd0;
        bitNext   = 3'd0;
        baudNext  = '0;
        stateNext = START;
      end
      START: begin
        if (lastBaud) begin
          baudNext  = '0;
          bitNext   = 3'd0;
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      DATA: begin
        if (lastBaud) begin
          baudNext = '0;
          if (bitCnt == 3'd7) stateNext = STOP;
          else                bitNext   = bitCnt + 3'd1;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      STOP: begin
        if (lastBaud) begin
          baudNext = '0;
          if (byteIdx == 2'd3) begin
            stateNext = DONE;
          end else begin
            byteNext  = byteIdx + 2'd1;
            stateNext = START;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      DONE: begin
        stateNext = rdempty ? IDLE : READ;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    rdreqNext    = (stateNext == READ);
    wordDoneNext = (stateNext == DONE);
    busyNext     = (stateNext inside {READ, LATCH, START, DATA, STOP});
    if (stateNext == START) begin
      txNext = 1'b0;
    end else if (stateNext == DATA) begin
      curByte = pickByte(wordNext, byteNext);
      txNext  = curByte[bitNext];
    end
  end

  // State, counters, word register and the registered outputs. Reset drops
  // any word in flight and returns the line to idle on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitCnt    <= 3'd0;
      byteIdx   <= 2'd0;
      wordReg   <= 32'h0;
      rdreq     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudNext;
      bitCnt    <= bitNext;
      byteIdx   <= byteNext;
      wordReg   <= wordNext;
      rdreq     <= rdreqNext;
      tx        <= txNext;
      busy      <= busyNext;
      word_done <= wordDoneNext;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_bridge.sv
// tb_fifo_uart_tx_bridge
//   Drives two bridges (MSB-first and LSB-first) from one behavioural FIFO and
//   compares every cycle against a per-word waveform schedule built from the
//   UART frame rules. A small UART receiver decodes both lines so that
//   literal byte values and event spacings can be pinned as well.

module tb_fifo_uart_tx_bridge;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdempty;
  logic [31:0] q = 32'h0;
  logic        rdreqM, txM, busyM, wdM;
  logic        rdreqL, txL, busyL, wdL;

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;
  logic checkEn   = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx_bridge #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .reset(reset), .rdempty(rdempty), .q(q),
    .rdreq(rdreqM), .tx(txM), .busy(busyM), .word_done(wdM)
  );

  fifo_uart_tx_bridge #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .reset(reset), .rdempty(rdempty), .q(q),
    .rdreq(rdreqL), .tx(txL), .busy(busyL), .word_done(wdL)
  );

  // Behavioural normal-mode FIFO: data appears on q the cycle after rdreq.
  // The noise bit can only make a non-empty FIFO look empty.
  logic [31:0] fifoMem [64];
  int          wrPtr = 0;
  int          rdPtr = 0;
  logic        noise = 1'b0;
  logic        noiseEn = 1'b0;

  assign rdempty = (wrPtr == rdPtr) || noise;

  always @(posedge clk) begin
    if (rdreqM && (wrPtr != rdPtr)) begin
      q     <= fifoMem[rdPtr % 64];
      rdPtr <= rdPtr + 1;
    end
  end

  always @(negedge clk) begin
    if (noiseEn) noise = 1'($urandom_range(0, 1));
    else         noise = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: per cycle, which values rdreq, both tx lines, busy and
  // word_done must show. A whole word is laid out as one schedule the moment
  // the model decides to fetch it.
  typedef struct packed {
    logic rdreq;
    logic txM;
    logic txL;
    logic busy;
    logic wd;
  } expT;

  localparam expT IDLE_EXP = '{rdreq: 1'b0, txM: 1'b1, txL: 1'b1, busy: 1'b0, wd: 1'b0};

  expT         sched[$];
  expT         expNow = IDLE_EXP;
  logic [31:0] modelQ[$];

  task automatic buildWord(input logic [31:0] w);
    logic [7:0] bM, bL;
    logic [9:0] frM, frL;
    sched.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    sched.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    for (int b = 0; b < 4; b++) begin
      bM  = 8'(w >> (8 * (3 - b)));
      bL  = 8'(w >> (8 * b));
      frM = {1'b1, bM, 1'b0};
      frL = {1'b1, bL, 1'b0};
      for (int i = 0; i < 10; i++)
        for (int c = 0; c < CPB; c++)
          sched.push_back('{1'b0, frM[i], frL[i], 1'b1, 1'b0});
    end
    sched.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
  endtask

  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      sched.delete();
      expNow = IDLE_EXP;
    end else begin
      if (sched.size() == 0 && !rdempty && modelQ.size() > 0)
        buildWord(modelQ.pop_front());
      if (sched.size() > 0) expNow = sched.pop_front();
      else                  expNow = IDLE_EXP;
    end
  end

  // Cycle-by-cycle comparison of both bridges against the schedule.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("outputs {rdreq,txM,txL,busy,wd}", {27'h0, rdreqM, txM, txL, busyM, wdM}, {27'h0, expNow});
      checkOutput("lsb dut {rdreq,busy,wd}", {29'h0, rdreqL, busyL, wdL},
                  {29'h0, expNow.rdreq, expNow.busy, expNow.wd});
    end
  end

  // UART receiver for both lines plus event logs used by the literal checks.
  logic       rxActive [2];
  int         rxPhase  [2];
  logic [7:0] rxShift  [2];
  logic [7:0] rxBytesM[$];
  logic [7:0] rxBytesL[$];
  int         startTimes[$];
  int         rdreqTimes[$];
  int         wdTimes[$];

  always @(negedge clk) begin : rxBlock
    logic t;
    if (reset) begin
      rxActive[0] = 1'b0;
      rxActive[1] = 1'b0;
    end else begin
      if (rdreqM) rdreqTimes.push_back(cycle);
      if (wdM)    wdTimes.push_back(cycle);
      for (int i = 0; i < 2; i++) begin
        t = (i == 0) ? txM : txL;
        if (!rxActive[i]) begin
          if (t === 1'b0) begin
            rxActive[i] = 1'b1;
            rxPhase[i]  = 0;
            if (i == 0) startTimes.push_back(cycle);
          end
        end else begin
          rxPhase[i]++;
          if ((rxPhase[i] % CPB) == CPB / 2 && rxPhase[i] >= CPB + CPB / 2 && rxPhase[i] <= 8 * CPB + CPB / 2)
            rxShift[i] = {t, rxShift[i][7:1]};
          if (rxPhase[i] == 9 * CPB + CPB / 2) begin
            rxActive[i] = 1'b0;
            if (i == 0) rxBytesM.push_back(rxShift[i]);
            else        rxBytesL.push_back(rxShift[i]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] packBytes(input logic [7:0] b[$], input int off);
    if (b.size() < off + 4) return 'x;
    return {b[off], b[off + 1], b[off + 2], b[off + 3]};
  endfunction

  task automatic applyStimulus(input logic [31:0] w);
    fifoMem[wrPtr % 64] = w;
    wrPtr++;
    modelQ.push_back(w);
  endtask

  task automatic clearLogs();
    rxBytesM.delete();
    rxBytesL.delete();
    startTimes.delete();
    rdreqTimes.delete();
    wdTimes.delete();
  endtask

  task automatic waitWordDone(input int target, input int budget);
    int n = 0;
    while (wdTimes.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("word_done within budget", {31'h0, wdTimes.size() >= target}, 32'h1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int          sCycle;
  int          dt;
  logic [31:0] rndWords[5];

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rdreq", {31'h0, rdreqM}, 32'h0);
    checkOutput("reset tx", {31'h0, txM}, 32'h1);
    checkOutput("reset busy", {31'h0, busyM}, 32'h0);
    checkOutput("reset word_done", {31'h0, wdM}, 32'h0);
    reset   = 1'b0;
    checkEn = 1'b1;

    // Empty FIFO: nothing may happen
    clearLogs();
    repeat (200) @(negedge clk);
    checkOutput("empty: rdreq pulses", rdreqTimes.size(), 32'd0);
    checkOutput("empty: start bits", startTimes.size(), 32'd0);

    // Single word, both byte orders
    $display("[TB] single word 0xA1B2C3D4");
    clearLogs();
    applyStimulus(32'hA1B2C3D4);
    waitWordDone(1, 400);
    repeat (3) @(negedge clk);
    checkOutput("single: rdreq pulses", rdreqTimes.size(), 32'd1);
    dt = (rdreqTimes.size() > 0 && startTimes.size() > 0) ? startTimes[0] - rdreqTimes[0] : -1;
    checkOutput("single: rdreq to start", dt, 32'd2);
    dt = (wdTimes.size() > 0 && startTimes.size() > 0) ? wdTimes[0] - startTimes[0] : -1;
    checkOutput("single: start to word_done", dt, 32'd160);
    checkOutput("single: msb-first bytes", packBytes(rxBytesM, 0), 32'hA1B2C3D4);
    checkOutput("single: lsb-first bytes", packBytes(rxBytesL, 0), 32'hD4C3B2A1);

    // Two queued words back to back
    $display("[TB] back-to-back words");
    clearLogs();
    applyStimulus(32'h00000001);
    applyStimulus(32'hFFFFFFFF);
    waitWordDone(2, 800);
    repeat (3) @(negedge clk);
    checkOutput("b2b: rdreq pulses", rdreqTimes.size(), 32'd2);
    dt = (rdreqTimes.size() > 1 && wdTimes.size() > 0) ? rdreqTimes[1] - wdTimes[0] : -1;
    checkOutput("b2b: word_done to next rdreq", dt, 32'd1);
    checkOutput("b2b: msb word0", packBytes(rxBytesM, 0), 32'h00000001);
    checkOutput("b2b: msb word1", packBytes(rxBytesM, 4), 32'hFFFFFFFF);
    checkOutput("b2b: lsb word0", packBytes(rxBytesL, 0), 32'h01000000);
    checkOutput("b2b: lsb word1", packBytes(rxBytesL, 4), 32'hFFFFFFFF);

    // Reset during the second data bit of the first byte
    $display("[TB] reset mid-word");
    clearLogs();
    applyStimulus(32'h5A3C96E1);
    begin : waitStart
      int n = 0;
      while (startTimes.size() == 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("midreset: start seen", {31'h0, startTimes.size() > 0}, 32'h1);
    sCycle = (startTimes.size() > 0) ? startTimes[0] : cycle;
    while (cycle < sCycle + 2 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset: tx idle", {31'h0, txM}, 32'h1);
    checkOutput("midreset: busy low", {31'h0, busyM}, 32'h0);
    checkOutput("midreset: no word_done", {31'h0, wdM}, 32'h0);
    reset = 1'b0;
    clearLogs();
    repeat (100) @(negedge clk);
    checkOutput("midreset: later rdreq", rdreqTimes.size(), 32'd0);
    checkOutput("midreset: later start bits", startTimes.size(), 32'd0);
    checkOutput("midreset: later word_done", wdTimes.size(), 32'd0);

    // Random words with rdempty noise
    $display("[TB] random words with rdempty noise");
    clearLogs();
    noiseEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rndWords[i] = $urandom;
      applyStimulus(rndWords[i]);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    waitWordDone(5, 2500);
    noiseEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("random: rdreq pulses", rdreqTimes.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("random: msb word", packBytes(rxBytesM, 4 * i), rndWords[i]);
      checkOutput("random: lsb word", packBytes(rxBytesL, 4 * i),
                  {rndWords[i][7:0], rndWords[i][15:8], rndWords[i][23:16], rndWords[i][31:24]});
    end

    repeat (5) @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
